// File: rtl/keypad_events_pkg.sv
// Shared types and defaults for the keypad event block: the queued event record,
// the scanner state encoding and the default parameter values.
package keypad_events_pkg;

   localparam int NUM_KEYS_DEFAULT       = 16;
   localparam int DEBOUNCE_TICKS_DEFAULT = 2;
   localparam int FIFO_DEPTH_DEFAULT     = 4;

   // Wide enough for the largest legal keypad (64 keys) and the largest debounce count (15).
   localparam int MAX_IDX_W = 6;
   localparam int CNT_W     = 4;

   typedef struct packed {
      logic [MAX_IDX_W-1:0] index;
      logic                 press;
   } key_event_t;

   typedef enum logic {
      SCAN_IDLE,
      SCAN_RUN
   } scan_state_t;

endpackage

// File: rtl/keypad_event_fifo.sv
// Small event queue with registered head outputs and a sticky overflow flag.
// A push into a full queue is accepted only when a pop frees a slot in the same cycle.
module keypad_event_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   input  logic             clr_overflow,
   output logic             valid,
   output logic [WIDTH-1:0] head,
   output logic             overflow
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_ptr_next;
   logic [PTR_W:0]   count, count_next;
   logic             full, pop_ok, push_ok, drop;
   logic [WIDTH-1:0] head_next;

   // NOTE: every signal driven here gets a value before any branch, so no latch can be inferred.
   always_comb begin
      full        = (count == (PTR_W + 1)'(DEPTH));
      pop_ok      = pop && (count != '0);
      push_ok     = push && (!full || pop_ok);
      drop        = push && full && !pop_ok;
      rd_ptr_next = pop_ok ? rd_ptr + 1'b1 : rd_ptr;
      count_next  = count + (PTR_W + 1)'(push_ok) - (PTR_W + 1)'(pop_ok);
      // The entry being written this cycle becomes the head when it lands on the next read slot.
      head_next   = (push_ok && (wr_ptr == rd_ptr_next)) ? push_data : mem[rd_ptr_next];
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         valid    <= 1'b0;
         head     <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         rd_ptr <= rd_ptr_next;
         count  <= count_next;
         valid  <= (count_next != '0);
         head   <= (count_next != '0) ? head_next : '0;
         if (drop)              overflow <= 1'b1;
         else if (clr_overflow) overflow <= 1'b0;
      end
   end

   // NOTE: storage is not reset; the pointers and count define which entries are meaningful.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/keypad_events.sv
// Keypad front end: synchronises raw key levels and the frame tick, debounces each key
// on tick edges, and scans changed keys in index order into a press/release event queue.
module keypad_events
   import keypad_events_pkg::*;
#(
   parameter int NUM_KEYS       = NUM_KEYS_DEFAULT,
   parameter int IDX_W          = $clog2(NUM_KEYS),
   parameter int DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEFAULT,
   parameter int FIFO_DEPTH     = FIFO_DEPTH_DEFAULT
)(
   input  logic                clk,
   input  logic                reset,
   input  logic                tick,
   input  logic [NUM_KEYS-1:0] keypad_matrix,
   input  logic                pop,
   input  logic                clr_overflow,
   output logic [NUM_KEYS-1:0] key_state,
   output logic                ev_valid,
   output logic [IDX_W-1:0]    ev_index,
   output logic                ev_press,
   output logic                any_pressed,
   output logic                release_trigger,
   output logic [IDX_W-1:0]    last_index,
   output logic                overflow
);

   logic [NUM_KEYS-1:0] key_meta, key_sync;
   logic                tick_meta, tick_sync, tick_sync_d, tick_pulse;
   logic [CNT_W-1:0]    cnt      [NUM_KEYS];
   logic [CNT_W-1:0]    cnt_next [NUM_KEYS];
   logic [NUM_KEYS-1:0] key_state_next, key_state_d, pending, pending_next, visit_mask;
   scan_state_t         state, state_next;
   logic [IDX_W-1:0]    scan_idx;
   logic                at_last, visit, push;
   key_event_t          push_event, head_event;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         key_meta    <= '0;
         key_sync    <= '0;
         tick_meta   <= 1'b0;
         tick_sync   <= 1'b0;
         tick_sync_d <= 1'b0;
      end else begin
         key_meta    <= keypad_matrix;
         key_sync    <= key_meta;
         tick_meta   <= tick;
         tick_sync   <= tick_meta;
         tick_sync_d <= tick_sync;
      end
   end

   assign tick_pulse = tick_sync & ~tick_sync_d;

   // A key must disagree with its accepted level on DEBOUNCE_TICKS consecutive ticks to flip.
   always_comb begin
      key_state_next = key_state;
      pending_next   = pending & ~visit_mask;
      for (int k = 0; k < NUM_KEYS; k++) begin
         cnt_next[k] = cnt[k];
         if (tick_pulse) begin
            if (key_sync[k] != key_state[k]) begin
               if (cnt[k] + CNT_W'(1) == CNT_W'(DEBOUNCE_TICKS)) begin
                  key_state_next[k] = ~key_state[k];
                  pending_next[k]   = 1'b1;
                  cnt_next[k]       = '0;
               end else begin
                  cnt_next[k] = cnt[k] + CNT_W'(1);
               end
            end else begin
               cnt_next[k] = '0;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         key_state   <= '0;
         key_state_d <= '0;
         pending     <= '0;
         for (int k = 0; k < NUM_KEYS; k++) cnt[k] <= '0;
      end else begin
         key_state   <= key_state_next;
         key_state_d <= key_state;
         pending     <= pending_next;
         for (int k = 0; k < NUM_KEYS; k++) cnt[k] <= cnt_next[k];
      end
   end

   assign at_last = (scan_idx == IDX_W'(NUM_KEYS - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= SCAN_IDLE;
         scan_idx <= '0;
      end else begin
         state <= state_next;
         if (tick_pulse)                scan_idx <= '0;
         else if (state == SCAN_RUN)    scan_idx <= at_last ? '0 : scan_idx + 1'b1;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         SCAN_IDLE: if (tick_pulse) state_next = SCAN_RUN;
         SCAN_RUN:  if (!tick_pulse && at_last) state_next = SCAN_IDLE;
         default:   state_next = SCAN_IDLE;
      endcase
   end

   // No key is visited on a tick cycle, so a restart never races a pending flag being set.
   always_comb begin
      visit            = (state == SCAN_RUN) && !tick_pulse;
      push             = visit && pending[scan_idx];
      visit_mask       = '0;
      if (push) visit_mask[scan_idx] = 1'b1;
      push_event.index = MAX_IDX_W'(scan_idx);
      push_event.press = key_state[scan_idx];
   end

   keypad_event_fifo #(
      .WIDTH ($bits(key_event_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk          (clk),
      .reset        (reset),
      .push         (push),
      .push_data    (push_event),
      .pop          (pop),
      .clr_overflow (clr_overflow),
      .valid        (ev_valid),
      .head         (head_event),
      .overflow     (overflow)
   );

   assign ev_index = head_event.index[IDX_W-1:0];
   assign ev_press = head_event.press;

   // Tracks every press pushed, including one the full queue drops.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                          last_index <= '0;
      else if (push && push_event.press)  last_index <= scan_idx;
   end

   assign any_pressed     = |key_state;
   assign release_trigger = (|key_state_d) & ~(|key_state);

endmodule

// File: tb/tb_keypad_events.sv
// Directed bench for keypad_events: debounce, scan ordering, queue overflow,
// full-queue push with pop, and reset in the middle of a scan.
module tb_keypad_events;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        tick = 1'b0;
   logic [15:0] keypad_matrix = '0;
   logic        pop = 1'b0;
   logic        clr_overflow = 1'b0;
   logic [15:0] key_state;
   logic        ev_valid;
   logic [3:0]  ev_index;
   logic        ev_press;
   logic        any_pressed;
   logic        release_trigger;
   logic [3:0]  last_index;
   logic        overflow;

   int n_checks = 0;
   int n_pass   = 0;

   keypad_events #(
      .NUM_KEYS       (16),
      .IDX_W          (4),
      .DEBOUNCE_TICKS (2),
      .FIFO_DEPTH     (4)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .tick            (tick),
      .keypad_matrix   (keypad_matrix),
      .pop             (pop),
      .clr_overflow    (clr_overflow),
      .key_state       (key_state),
      .ev_valid        (ev_valid),
      .ev_index        (ev_index),
      .ev_press        (ev_press),
      .any_pressed     (any_pressed),
      .release_trigger (release_trigger),
      .last_index      (last_index),
      .overflow        (overflow)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1);
   end

   // One tick rising edge followed by 24 clocks (covers sync, debounce and a full scan).
   // Edge i=3+k carries the scan visit of key k into the queue at edge i=4+k.
   task automatic run_tick(input int pop_at, input int rst_at,
                           output int valid_at, output int rel_pulses);
      valid_at   = -1;
      rel_pulses = 0;
      @(posedge clk); #1 tick = 1'b1;
      for (int i = 1; i <= 24; i++) begin
         @(posedge clk); #1;
         if (ev_valid && valid_at < 0) valid_at = i;
         if (release_trigger) rel_pulses++;
         pop = (i == pop_at);
         if (i == 3) tick = 1'b0;
         if (i == rst_at) reset = 1'b1;
      end
      pop = 1'b0;
   endtask

   task automatic set_keys(input logic [15:0] v);
      keypad_matrix = v;
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic pop_one;
      pop = 1'b1;
      @(posedge clk); #1;
      pop = 1'b0;
   endtask

   task automatic test_reset;
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (key_state !== 16'h0) $display("FAIL reset_key_state: got %h want 0000", key_state); else n_pass++;
      n_checks++; if ({ev_valid, ev_index, ev_press} !== 6'h0) $display("FAIL reset_head: got v=%b idx=%0d p=%b want all 0", ev_valid, ev_index, ev_press); else n_pass++;
      n_checks++; if ({any_pressed, release_trigger, overflow, last_index} !== 7'h0) $display("FAIL reset_flags: got any=%b rel=%b ovf=%b last=%0d want all 0", any_pressed, release_trigger, overflow, last_index); else n_pass++;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_single_press;
      int va, rp;
      set_keys(16'h0020);
      run_tick(-1, -1, va, rp);
      n_checks++; if (key_state !== 16'h0000) $display("FAIL single_after_one_tick: got %h want 0000", key_state); else n_pass++;
      run_tick(-1, -1, va, rp);
      n_checks++; if (key_state !== 16'h0020) $display("FAIL single_key_state: got %h want 0020", key_state); else n_pass++;
      n_checks++; if (any_pressed !== 1'b1) $display("FAIL single_any_pressed: got %b want 1", any_pressed); else n_pass++;
      n_checks++; if (va !== 9) $display("FAIL single_valid_latency: got edge %0d want edge 9", va); else n_pass++;
      n_checks++; if (ev_valid !== 1'b1 || ev_index !== 4'd5 || ev_press !== 1'b1) $display("FAIL single_press_event: got v=%b idx=%0d p=%b want v=1 idx=5 p=1", ev_valid, ev_index, ev_press); else n_pass++;
      n_checks++; if (last_index !== 4'd5) $display("FAIL single_last_index: got %0d want 5", last_index); else n_pass++;
      pop_one();
      n_checks++; if (ev_valid !== 1'b0) $display("FAIL single_one_event: got v=%b want 0 after one pop", ev_valid); else n_pass++;
      set_keys(16'h0000);
      run_tick(-1, -1, va, rp);
      run_tick(-1, -1, va, rp);
      n_checks++; if (key_state !== 16'h0000 || any_pressed !== 1'b0) $display("FAIL single_release_state: got %h any=%b want 0000 any=0", key_state, any_pressed); else n_pass++;
      n_checks++; if (rp !== 1) $display("FAIL single_release_trigger: got %0d pulses want 1", rp); else n_pass++;
      n_checks++; if (ev_valid !== 1'b1 || ev_index !== 4'd5 || ev_press !== 1'b0) $display("FAIL single_release_event: got v=%b idx=%0d p=%b want v=1 idx=5 p=0", ev_valid, ev_index, ev_press); else n_pass++;
      n_checks++; if (last_index !== 4'd5) $display("FAIL single_last_after_release: got %0d want 5", last_index); else n_pass++;
      pop_one();
   endtask

   task automatic test_glitch;
      int va, rp;
      set_keys(16'h0008);
      run_tick(-1, -1, va, rp);
      set_keys(16'h0000);
      run_tick(-1, -1, va, rp);
      run_tick(-1, -1, va, rp);
      n_checks++; if (key_state !== 16'h0000) $display("FAIL glitch_key_state: got %h want 0000", key_state); else n_pass++;
      n_checks++; if (ev_valid !== 1'b0) $display("FAIL glitch_no_event: got v=%b idx=%0d want v=0", ev_valid, ev_index); else n_pass++;
   endtask

   task automatic test_multi_press;
      int va, rp;
      logic [3:0] exp_idx [3];
      exp_idx = '{4'd2, 4'd9, 4'd14};
      set_keys(16'h4204);
      run_tick(-1, -1, va, rp);
      run_tick(-1, -1, va, rp);
      n_checks++; if (key_state !== 16'h4204) $display("FAIL multi_key_state: got %h want 4204", key_state); else n_pass++;
      n_checks++; if (last_index !== 4'd14) $display("FAIL multi_last_index: got %0d want 14", last_index); else n_pass++;
      for (int j = 0; j < 3; j++) begin
         n_checks++; if (ev_valid !== 1'b1 || ev_index !== exp_idx[j] || ev_press !== 1'b1) $display("FAIL multi_press_order[%0d]: got v=%b idx=%0d p=%b want v=1 idx=%0d p=1", j, ev_valid, ev_index, ev_press, exp_idx[j]); else n_pass++;
         pop_one();
      end
      n_checks++; if (ev_valid !== 1'b0) $display("FAIL multi_press_drained: got v=%b want 0", ev_valid); else n_pass++;
      set_keys(16'h0000);
      run_tick(-1, -1, va, rp);
      run_tick(-1, -1, va, rp);
      n_checks++; if (rp !== 1) $display("FAIL multi_release_trigger: got %0d pulses want 1", rp); else n_pass++;
      for (int j = 0; j < 3; j++) begin
         n_checks++; if (ev_valid !== 1'b1 || ev_index !== exp_idx[j] || ev_press !== 1'b0) $display("FAIL multi_release_order[%0d]: got v=%b idx=%0d p=%b want v=1 idx=%0d p=0", j, ev_valid, ev_index, ev_press, exp_idx[j]); else n_pass++;
         pop_one();
      end
      n_checks++; if (last_index !== 4'd14) $display("FAIL multi_last_after_release: got %0d want 14", last_index); else n_pass++;
   endtask

   task automatic test_overflow;
      int va, rp;
      set_keys(16'h001F);
      run_tick(-1, -1, va, rp);
      run_tick(-1, -1, va, rp);
      n_checks++; if (overflow !== 1'b1) $display("FAIL overflow_set: got %b want 1", overflow); else n_pass++;
      n_checks++; if (last_index !== 4'd4) $display("FAIL overflow_last_index_dropped: got %0d want 4", last_index); else n_pass++;
      n_checks++; if (ev_valid !== 1'b1 || ev_index !== 4'd0 || ev_press !== 1'b1) $display("FAIL overflow_head: got v=%b idx=%0d p=%b want v=1 idx=0 p=1", ev_valid, ev_index, ev_press); else n_pass++;
      clr_overflow = 1'b1;
      @(posedge clk); #1;
      clr_overflow = 1'b0;
      n_checks++; if (overflow !== 1'b0) $display("FAIL overflow_clear: got %b want 0", overflow); else n_pass++;
      n_checks++; if (ev_valid !== 1'b1 || ev_index !== 4'd0) $display("FAIL overflow_clear_keeps_head: got v=%b idx=%0d want v=1 idx=0", ev_valid, ev_index); else n_pass++;
   endtask

   task automatic test_full_push_pop;
      int va, rp;
      logic [3:0] exp_idx [4];
      logic       exp_prs [4];
      exp_idx = '{4'd1, 4'd2, 4'd3, 4'd4};
      exp_prs = '{1'b1, 1'b1, 1'b1, 1'b0};
      set_keys(16'h000F);
      run_tick(-1, -1, va, rp);
      run_tick(7, -1, va, rp);
      n_checks++; if (overflow !== 1'b0) $display("FAIL full_pop_push_overflow: got %b want 0", overflow); else n_pass++;
      for (int j = 0; j < 4; j++) begin
         n_checks++; if (ev_valid !== 1'b1 || ev_index !== exp_idx[j] || ev_press !== exp_prs[j]) $display("FAIL full_pop_push_entry[%0d]: got v=%b idx=%0d p=%b want v=1 idx=%0d p=%b", j, ev_valid, ev_index, ev_press, exp_idx[j], exp_prs[j]); else n_pass++;
         pop_one();
      end
      n_checks++; if (ev_valid !== 1'b0) $display("FAIL full_pop_push_count: got v=%b want 0 after 4 pops", ev_valid); else n_pass++;
      pop_one();
      n_checks++; if (ev_valid !== 1'b0 || overflow !== 1'b0) $display("FAIL empty_pop_ignored: got v=%b ovf=%b want v=0 ovf=0", ev_valid, overflow); else n_pass++;
      set_keys(16'h0000);
      run_tick(-1, -1, va, rp);
      run_tick(-1, -1, va, rp);
      for (int j = 0; j < 4; j++) begin
         n_checks++; if (ev_valid !== 1'b1 || ev_index !== 4'(j) || ev_press !== 1'b0) $display("FAIL low_release_order[%0d]: got v=%b idx=%0d p=%b want v=1 idx=%0d p=0", j, ev_valid, ev_index, ev_press, j); else n_pass++;
         pop_one();
      end
   endtask

   task automatic test_reset_mid_scan;
      int va, rp;
      set_keys(16'h1C00);
      run_tick(-1, -1, va, rp);
      run_tick(-1, 5, va, rp);
      n_checks++; if (key_state !== 16'h0000 || any_pressed !== 1'b0) $display("FAIL midreset_key_state: got %h any=%b want 0000 any=0", key_state, any_pressed); else n_pass++;
      n_checks++; if ({ev_valid, ev_index, ev_press} !== 6'h0) $display("FAIL midreset_head: got v=%b idx=%0d p=%b want all 0", ev_valid, ev_index, ev_press); else n_pass++;
      n_checks++; if ({release_trigger, overflow, last_index} !== 6'h0) $display("FAIL midreset_flags: got rel=%b ovf=%b last=%0d want all 0", release_trigger, overflow, last_index); else n_pass++;
      reset = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      n_checks++; if (key_state !== 16'h0000 || ev_valid !== 1'b0) $display("FAIL midreset_no_early_event: got %h v=%b want 0000 v=0", key_state, ev_valid); else n_pass++;
      run_tick(-1, -1, va, rp);
      n_checks++; if (key_state !== 16'h0000 || ev_valid !== 1'b0) $display("FAIL midreset_one_tick: got %h v=%b want 0000 v=0", key_state, ev_valid); else n_pass++;
      run_tick(-1, -1, va, rp);
      n_checks++; if (key_state !== 16'h1C00) $display("FAIL midreset_key_state_after: got %h want 1c00", key_state); else n_pass++;
      for (int j = 0; j < 3; j++) begin
         n_checks++; if (ev_valid !== 1'b1 || ev_index !== 4'(10 + j) || ev_press !== 1'b1) $display("FAIL midreset_event[%0d]: got v=%b idx=%0d p=%b want v=1 idx=%0d p=1", j, ev_valid, ev_index, ev_press, 10 + j); else n_pass++;
         pop_one();
      end
      n_checks++; if (ev_valid !== 1'b0 || last_index !== 4'd12) $display("FAIL midreset_tail: got v=%b last=%0d want v=0 last=12", ev_valid, last_index); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single_press();
      test_glitch();
      test_multi_press();
      test_overflow();
      test_full_push_pop();
      test_reset_mid_scan();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
